// File: rtl/rr_onehot_scheduler.sv
// Round-robin scheduler for 8 requesters: one-hot registered grant, hold limit
// with timeout pulse, and a forced dead cycle between successive owners.
module rr_onehot_scheduler #(
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned HOLD_W   = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] gnt_idx,
   output logic       gnt_vld,
   output logic       timeout
);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
   localparam logic [HOLD_W-1:0] HOLD_SAT  = {HOLD_W{1'b1}};

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t            state, state_n;
   logic [2:0]        ptr, ptr_n;
   logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
   logic [7:0]        gnt_n;
   logic [2:0]        gnt_idx_n;
   logic              gnt_vld_n;
   logic              timeout_n;
   logic [2:0]        win;
   logic [2:0]        cand;
   logic              found;

   // Rotating priority search: first set request at or above ptr, wrapping.
   always_comb begin
      win   = '0;
      found = 1'b0;
      cand  = '0;
      for (int unsigned k = 0; k < 8; k++) begin
         cand = ptr + 3'(k);
         if (!found && req[cand]) begin
            win   = cand;
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= '0;
         hold_cnt <= '0;
         gnt      <= '0;
         gnt_idx  <= '0;
         gnt_vld  <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         state    <= state_n;
         ptr      <= ptr_n;
         hold_cnt <= hold_cnt_n;
         gnt      <= gnt_n;
         gnt_idx  <= gnt_idx_n;
         gnt_vld  <= gnt_vld_n;
         timeout  <= timeout_n;
      end
   end

   always_comb begin
      state_n    = state;
      ptr_n      = ptr;
      hold_cnt_n = hold_cnt;
      gnt_n      = gnt;
      gnt_idx_n  = gnt_idx;
      gnt_vld_n  = gnt_vld;
      timeout_n  = 1'b0;
      unique case (state)
         IDLE: begin
            if (en && found) begin
               state_n    = GRANT;
               gnt_idx_n  = win;
               gnt_n      = 8'(1) << win;
               gnt_vld_n  = 1'b1;
               hold_cnt_n = '0;
            end
         end
         GRANT: begin
            if (!req[gnt_idx] || (MAX_HOLD != 0 && hold_cnt == HOLD_LAST)) begin
               // Releaser drops to lowest priority for the next arbitration.
               state_n   = IDLE;
               gnt_n     = '0;
               gnt_vld_n = 1'b0;
               ptr_n     = gnt_idx + 3'd1;
               timeout_n = req[gnt_idx];
            end else if (hold_cnt != HOLD_SAT) begin
               hold_cnt_n = hold_cnt + HOLD_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_rr_onehot_scheduler.sv
// Directed bench for rr_onehot_scheduler with a 4-cycle hold limit.
module tb_rr_onehot_scheduler;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_vld;
   logic       timeout;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rr_onehot_scheduler #(.MAX_HOLD(4), .HOLD_W(3)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .req     (req),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld),
      .timeout (timeout)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Idle expectation: no grant; timeout as given.
   task automatic exp_idle(input string tag, input logic eto);
      chk({tag, ".gnt"}, gnt, 8'h00);
      chk({tag, ".vld"}, 8'(gnt_vld), 8'h00);
      chk({tag, ".timeout"}, 8'(timeout), 8'(eto));
   endtask

   // Granted expectation: one-hot of idx, valid set, no timeout.
   task automatic exp_gnt(input string tag, input logic [2:0] idx);
      logic [7:0] oh;
      oh = 8'h01 << idx;
      chk({tag, ".gnt"}, gnt, oh);
      chk({tag, ".idx"}, 8'(gnt_idx), 8'(idx));
      chk({tag, ".vld"}, 8'(gnt_vld), 8'h01);
      chk({tag, ".timeout"}, 8'(timeout), 8'h00);
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b1;
      req   = 8'hFF;

      // reset held with all requests raised
      for (int i = 0; i < 3; i++) begin
         tick();
         exp_idle($sformatf("reset%0d", i), 1'b0);
      end

      // basic
      rst_n = 1'b1;
      req   = 8'h24;
      tick();
      exp_gnt("basic_first", 3'd2);
      req = 8'h20;
      tick();
      exp_idle("basic_dead", 1'b0);
      tick();
      exp_gnt("basic_second", 3'd5);
      req = 8'h00;
      tick();
      exp_idle("basic_release", 1'b0);

      // fairness wrap from ptr=0
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      req   = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         logic [7:0] drop;
         tick();
         exp_gnt($sformatf("rr%0d_a", k), 3'(k % 8));
         tick();
         exp_gnt($sformatf("rr%0d_b", k), 3'(k % 8));
         drop = 8'h01 << (k % 8);
         req  = 8'hFF & ~drop;
         tick();
         exp_idle($sformatf("rr%0d_dead", k), 1'b0);
         req = 8'hFF;
      end
      req = 8'h00;
      tick();
      exp_idle("rr_quiet", 1'b0);

      // hold limit: 4 grant cycles, timeout pulse, re-grant
      req = 8'h01;
      for (int i = 0; i < 4; i++) begin
         tick();
         exp_gnt($sformatf("hold%0d", i), 3'd0);
      end
      tick();
      exp_idle("timeout_pulse", 1'b1);
      tick();
      exp_gnt("regrant", 3'd0);
      req = 8'h00;
      tick();
      exp_idle("regrant_release", 1'b0);

      // enable gating
      en  = 1'b0;
      req = 8'h10;
      tick();
      exp_idle("en_block0", 1'b0);
      tick();
      exp_idle("en_block1", 1'b0);
      en = 1'b1;
      tick();
      exp_gnt("en_grant", 3'd4);
      en = 1'b0;
      tick();
      exp_gnt("en_hold0", 3'd4);
      tick();
      exp_gnt("en_hold1", 3'd4);
      req = 8'h00;
      tick();
      exp_idle("en_release", 1'b0);
      en = 1'b1;

      // reset mid-grant restores ptr=0
      req = 8'h08;
      tick();
      exp_gnt("mid_grant", 3'd3);
      rst_n = 1'b0;
      req   = 8'h09;
      tick();
      exp_idle("mid_reset", 1'b0);
      rst_n = 1'b1;
      tick();
      exp_gnt("post_reset", 3'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
